// File: rtl/key_sequencer.sv
// key_sequencer: turns UART scancode bytes into timed key taps on the
// 40-bit Spectrum key matrix. Bytes are buffered in a FIFO, then each is
// played out as press, hold (HOLD_CYCLES), release, gap (GAP_CYCLES).
// Optional build macro STICKY_SHIFT_EN: codes 41 (CS) and 49 (SS) latch as
// pending modifiers and are pressed together with the next key tap.
module key_sequencer #(
    parameter int unsigned HOLD_CYCLES = 1080000,
    parameter int unsigned GAP_CYCLES  = 540000,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        flush,
    output logic [39:0] key_matrix,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW       = AW + 1;

    localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]   GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HOLD,
        GAP
    } state_t;

    // Scancode to matrix bit; zero for unmapped codes.
    function automatic logic [39:0] decode_key(input logic [7:0] code);
        logic [39:0] m;
        m = '0;
        case (code)
            8'h15: m[0]  = 1'b1;
            8'h1D: m[1]  = 1'b1;
            8'h24: m[2]  = 1'b1;
            8'h2D: m[3]  = 1'b1;
            8'h2C: m[4]  = 1'b1;
            8'h1C: m[5]  = 1'b1;
            8'h1B: m[6]  = 1'b1;
            8'h23: m[7]  = 1'b1;
            8'h2B: m[8]  = 1'b1;
            8'h34: m[9]  = 1'b1;
            8'h1A: m[10] = 1'b1;
            8'h22: m[11] = 1'b1;
            8'h21: m[12] = 1'b1;
            8'h2A: m[13] = 1'b1;
            8'h32: m[14] = 1'b1;
            8'h16: m[15] = 1'b1;
            8'h1E: m[16] = 1'b1;
            8'h26: m[17] = 1'b1;
            8'h25: m[18] = 1'b1;
            8'h2E: m[19] = 1'b1;
            8'h45: m[20] = 1'b1;
            8'h46: m[21] = 1'b1;
            8'h3E: m[22] = 1'b1;
            8'h3D: m[23] = 1'b1;
            8'h36: m[24] = 1'b1;
            8'h41: m[25] = 1'b1;
            8'h49: m[26] = 1'b1;
            8'h5A: m[27] = 1'b1;
            8'h31: m[28] = 1'b1;
            8'h29: m[29] = 1'b1;
            8'h3A: m[30] = 1'b1;
            8'h4D: m[31] = 1'b1;
            8'h44: m[32] = 1'b1;
            8'h43: m[33] = 1'b1;
            8'h3C: m[34] = 1'b1;
            8'h35: m[35] = 1'b1;
            8'h4B: m[36] = 1'b1;
            8'h42: m[37] = 1'b1;
            8'h3B: m[38] = 1'b1;
            8'h33: m[39] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Input capture stage
    logic            cap_valid_q;
    logic [7:0]      cap_data_q;

    // Scancode FIFO
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CNTW-1:0] fifo_count_q;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_wr;
    logic            fifo_rd;
    logic            fifo_drop;

    // Tap sequencer
    state_t          state_q;
    state_t          state_d;
    logic [7:0]      code_q;
    logic [CW-1:0]   cnt_q;
    logic [39:0]     tap_mask;
    logic [39:0]     press_mask;
    logic            mod_hit;
    logic            start_tap;
    logic            end_hold;
    logic            set_mod;
`ifdef STICKY_SHIFT_EN
    logic [1:0]      mods_q;
`endif

    assign fifo_empty = (fifo_count_q == '0);
    assign fifo_full  = (fifo_count_q == FIFO_FULL);

    // State register; flush and reset both abort to IDLE.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the press/hold/gap cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = PRESS;
            PRESS:   state_d = start_tap ? HOLD : IDLE;
            HOLD:    if (cnt_q == '0) state_d = GAP;
            GAP:     if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes and status derived from registered state only.
    always_comb begin
        tap_mask = decode_key(code_q);
`ifdef STICKY_SHIFT_EN
        mod_hit    = (code_q == 8'h41) || (code_q == 8'h49);
        press_mask = tap_mask | {13'b0, mods_q, 25'b0};
`else
        mod_hit    = 1'b0;
        press_mask = tap_mask;
`endif
        fifo_rd   = (state_q == IDLE) && !fifo_empty;
        fifo_wr   = cap_valid_q && (!fifo_full || fifo_rd);
        fifo_drop = cap_valid_q && fifo_full && !fifo_rd;
        start_tap = (state_q == PRESS) && (tap_mask != '0) && !mod_hit;
        set_mod   = (state_q == PRESS) && mod_hit;
        end_hold  = (state_q == HOLD) && (cnt_q == '0);
        busy      = (state_q != IDLE) || !fifo_empty || cap_valid_q;
    end

    // Capture incoming bytes; the one-cycle stage gives the N+3 press latency
    // and lets a flush discard a byte arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
        end else begin
            cap_valid_q <= rx_valid;
            cap_data_q  <= rx_data;
        end
    end

    // FIFO storage; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (fifo_wr && !reset && !flush) begin
            fifo_mem[wr_ptr_q] <= cap_data_q;
        end
    end

    // FIFO pointers, occupancy and head pop into the code register.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count_q <= fifo_count_q + CNTW'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CNTW'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
        if (reset) begin
            code_q <= '0;
        end else if (fifo_rd && !flush) begin
            code_q <= fifo_mem[rd_ptr_q];
        end
    end

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifo_drop && !flush) begin
            overflow <= 1'b1;
        end
    end

    // Key matrix and hold/gap timer.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            key_matrix <= '0;
            cnt_q      <= '0;
        end else if (start_tap) begin
            key_matrix <= press_mask;
            cnt_q      <= HOLD_LOAD;
        end else if (end_hold) begin
            key_matrix <= '0;
            cnt_q      <= GAP_LOAD;
        end else if (((state_q == HOLD) || (state_q == GAP)) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

`ifdef STICKY_SHIFT_EN
    // Pending modifiers: set by CS/SS codes, cleared when the tap releases.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mods_q <= '0;
        end else if (end_hold) begin
            mods_q <= '0;
        end else if (set_mod) begin
            mods_q <= mods_q | {(code_q == 8'h49), (code_q == 8'h41)};
        end
    end
`else
    // Without sticky modifiers the CS/SS codes tap like any other key.
    always_comb begin
        if (set_mod) begin
            // unreachable: mod_hit is tied low in this build
        end
    end
`endif

endmodule

// File: tb/tb_key_sequencer.sv
// Scoreboard bench for key_sequencer (HOLD=4, GAP=2, DEPTH=4).
// Stimulus pushes expected tap masks from a table-driven model; a monitor
// pops and checks each observed tap, its hold length and the preceding gap.
module tb_key_sequencer;

    localparam int HOLD  = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        flush;
    logic [39:0] key_matrix;
    logic        busy;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [39:0] exp_q [$];
    logic [1:0]  pend;
    bit          abort_tap;
    logic [7:0]  code_tab [40];

    key_sequencer #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .flush     (flush),
        .key_matrix(key_matrix),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic logic [39:0] code_to_mask(input logic [7:0] c);
        for (int i = 0; i < 40; i++) begin
            if (code_tab[i] == c) return 40'(1) << i;
        end
        return '0;
    endfunction

    // Reference model: what tap (if any) an accepted byte will produce.
    task automatic model_accept(input logic [7:0] c);
        logic [39:0] m;
        m = code_to_mask(c);
`ifdef STICKY_SHIFT_EN
        if (c == 8'h41) begin
            pend[0] = 1'b1;
        end else if (c == 8'h49) begin
            pend[1] = 1'b1;
        end else if (m != '0) begin
            exp_q.push_back(m | (pend[0] ? 40'(1) << 25 : 40'(0)) | (pend[1] ? 40'(1) << 26 : 40'(0)));
            pend = 2'b00;
        end
`else
        if (m != '0) exp_q.push_back(m);
`endif
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic f);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        flush    = f;
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d, 1'b0);
        model_accept(d);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        drive(1'b0, 8'h00, 1'b0);
        while (busy !== 1'b0) begin
            if (n >= budget) begin
                check("idle_timeout", 1'b0, 64'(n), 64'(budget));
                return;
            end
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_press(input int budget);
        int n;
        n = 0;
        while (key_matrix == '0) begin
            if (n >= budget) begin
                check("press_timeout", 1'b0, 64'(n), 64'(budget));
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: every rising tap must match the head of the scoreboard.
    logic [39:0] mon_prev;
    int          hold_cnt;
    int          gap_cnt;
    bit          seen_fall;
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            mon_prev  = '0;
            hold_cnt  = 0;
            gap_cnt   = 0;
            seen_fall = 1'b0;
        end else begin
            if (key_matrix != mon_prev) begin
                if (mon_prev == '0) begin
                    if (seen_fall) check("gap_len", gap_cnt >= GAP, 64'(gap_cnt), 64'(GAP));
                    if (exp_q.size() == 0) begin
                        check("unexpected_tap", 1'b0, 64'(key_matrix), 64'd0);
                    end else begin
                        logic [39:0] want;
                        want = exp_q.pop_front();
                        check("tap_mask", key_matrix == want, 64'(key_matrix), 64'(want));
                    end
                    hold_cnt = 1;
                end else if (key_matrix == '0) begin
                    if (abort_tap) abort_tap = 1'b0;
                    else check("hold_len", hold_cnt == HOLD, 64'(hold_cnt), 64'(HOLD));
                    gap_cnt   = 1;
                    seen_fall = 1'b1;
                end else begin
                    check("mask_changed", 1'b0, 64'(key_matrix), 64'(mon_prev));
                end
            end else if (key_matrix != '0) begin
                hold_cnt++;
            end else begin
                gap_cnt++;
            end
            mon_prev = key_matrix;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] want;
        logic [7:0]  code;
        int          n;
        code_tab = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                     8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
                     8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32,
                     8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                     8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
                     8'h41, 8'h49, 8'h5A, 8'h31, 8'h29, 8'h3A,
                     8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
                     8'h4B, 8'h42, 8'h3B, 8'h33};
        pend      = 2'b00;
        abort_tap = 1'b0;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_matrix", key_matrix == '0, 64'(key_matrix), 64'd0);
        check("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
        check("rst_overflow", overflow == 1'b0, 64'(overflow), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single tap: high on edges 3-6, busy drops at edge 9.
        send(8'h15);
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) drive(1'b0, 8'h00, 1'b0);
            else @(negedge clk);
            want = (k >= 3 && k <= 6) ? 40'h1 : 40'h0;
            check($sformatf("t1_matrix_e%0d", k), key_matrix == want, 64'(key_matrix), 64'(want));
            check($sformatf("t1_busy_e%0d", k), busy == (k < 9), 64'(busy), 64'(k < 9));
        end

        // Back-to-back taps keep order.
        send(8'h1C);
        send(8'h45);
        send(8'h5A);
        wait_idle(200);

        // Unmapped code produces nothing.
        send(8'hFF);
        send(8'h29);
        wait_idle(200);

        // Modifier followed by a digit.
        send(8'h41);
        send(8'h1E);
        wait_idle(200);

        // Randomised bursts that never exceed the FIFO.
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 3) != 0) code = code_tab[$urandom_range(0, 39)];
                else code = 8'($urandom_range(0, 255));
                send(code);
                if ($urandom_range(0, 2) == 0) drive(1'b0, 8'h00, 1'b0);
            end
            wait_idle(500);
        end
        check("no_overflow_yet", overflow == 1'b0, 64'(overflow), 64'd0);

        // Six bytes into an idle sequencer: one popped, four buffered, one dropped.
        send(8'h15);
        send(8'h1D);
        send(8'h24);
        send(8'h2D);
        send(8'h2C);
        drive(1'b1, 8'h1C, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("ovf_set", overflow == 1'b1, 64'(overflow), 64'd1);
        wait_idle(300);
        check("ovf_sticky", overflow == 1'b1, 64'(overflow), 64'd1);

        // Flush during HOLD discards queue and an in-flight byte.
        send(8'h16);
        send(8'h15);
        send(8'h1D);
        drive(1'b0, 8'h00, 1'b0);
        wait_press(20);
        check("flush_pre_key", key_matrix == (40'(1) << 15), 64'(key_matrix), 64'(40'(1) << 15));
        abort_tap = 1'b1;
        drive(1'b1, 8'h24, 1'b1);
        exp_q.delete();
        pend = 2'b00;
        drive(1'b0, 8'h00, 1'b0);
        check("flush_matrix", key_matrix == '0, 64'(key_matrix), 64'd0);
        check("flush_busy", busy == 1'b0, 64'(busy), 64'd0);
        check("flush_overflow", overflow == 1'b1, 64'(overflow), 64'd1);
        repeat (20) @(negedge clk);
        check("flush_quiet", key_matrix == '0 && busy == 1'b0, 64'({busy, key_matrix}), 64'd0);

        // Reset mid-HOLD clears everything including overflow.
        send(8'h2C);
        drive(1'b0, 8'h00, 1'b0);
        wait_press(20);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        pend = 2'b00;
        @(negedge clk);
        check("rst_hold_matrix", key_matrix == '0, 64'(key_matrix), 64'd0);
        check("rst_hold_busy", busy == 1'b0, 64'(busy), 64'd0);
        check("rst_hold_overflow", overflow == 1'b0, 64'(overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Recovery after reset.
        send(8'h1E);
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
